// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module  : fetch_ctrl
// Brief   : Instruction fetch sequencer. It owns the PC, issues fetches, and
//           queues the responses for decode. It handles redirects and halt.
//           Optional performance counters are enabled by FETCH_CTRL_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        fetch_en,
   output logic [15:0] fetch_addr,
   input  logic        fetch_ready,
   input  logic [15:0] fetch_instr,
   input  logic [15:0] fetch_pc,
   output logic        out_valid,
   output logic [15:0] out_instr,
   output logic [15:0] out_pc,
   input  logic        out_accept,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        halt,
   output logic        halted
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [15:0] perf_flush_cnt
`endif
);

   localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int SW = AW + 2;

   localparam logic [0:0] S_RUN  = 1'b0;
   localparam logic [0:0] S_HALT = 1'b1;

   localparam logic [15:0] c_reset_pc = RESET_PC & 16'hFFFE;

   logic [0:0]    r_state;
   logic [15:0]   r_pc;
   logic          r_inflight;
   logic          r_discard;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [15:0]   r_q_instr [QDEPTH];
   logic [15:0]   r_q_pc    [QDEPTH];

   logic          w_pop;
   logic          w_push;
   logic [SW-1:0] w_occupancy;
   logic [SW-1:0] w_limit;

   assign out_valid  = (r_count != '0);
   assign out_instr  = r_q_instr[r_rd_ptr];
   assign out_pc     = r_q_pc[r_rd_ptr];
   assign fetch_addr = r_pc;
   assign halted     = (r_state == S_HALT);

   assign w_pop       = out_valid && out_accept;
   // A response that lands in the redirect cycle belongs to the old path.
   assign w_push      = fetch_ready && !r_discard && !redirect;
   assign w_occupancy = SW'(r_count) + SW'(r_inflight);
   assign w_limit     = SW'(QDEPTH) + SW'(w_pop);

   // Dequeue credit lets a slot freed this cycle be reused immediately.
   assign fetch_en = !rst && (r_state == S_RUN) && !redirect && !halt &&
                     (w_occupancy < w_limit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_RUN;
         r_pc       <= c_reset_pc;
         r_inflight <= 1'b0;
         r_discard  <= 1'b0;
      end else begin
         r_inflight <= fetch_en;
         r_discard  <= redirect && r_inflight;
         if (redirect) begin
            r_state <= S_RUN;
            r_pc    <= redirect_pc & 16'hFFFE;
         end else begin
            if (r_state == S_RUN && halt) begin
               r_state <= S_HALT;
            end
            if (fetch_en) begin
               r_pc <= r_pc + 16'd2;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            r_q_instr[i] <= '0;
            r_q_pc[i]    <= '0;
         end
      end else if (redirect) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_q_instr[r_wr_ptr] <= fetch_instr;
            r_q_pc[r_wr_ptr]    <= fetch_pc;
            r_wr_ptr            <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (r_state == S_RUN && !fetch_en && !redirect &&
             perf_stall_cnt != 32'hFFFF_FFFF) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (redirect && (out_valid || r_inflight) &&
             perf_flush_cnt != 16'hFFFF) begin
            perf_flush_cnt <= perf_flush_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire
